// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, mem_size codes,
// divider state encoding.
package cpu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLT   = 5'd2;
  localparam logic [4:0] OP_SLTU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MUL   = 5'd12;
  localparam logic [4:0] OP_MULH  = 5'd13;
  localparam logic [4:0] OP_MULHU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MOD   = 5'd17;
  localparam logic [4:0] OP_MODU  = 5'd18;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  function automatic logic is_div_op(
    input logic [4:0] op
  );
    return (op >= OP_DIV) && (op <= OP_MODU);
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: data-SRAM request bus driven
// by the execute stage toward memory.
interface exe_stage_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output data_sram_en,
    output data_sram_we,
    output data_sram_addr,
    output data_sram_wdata
  );

  modport slave (
    input data_sram_en,
    input data_sram_we,
    input data_sram_addr,
    input data_sram_wdata
  );

endinterface

// File: rtl/exe_div.sv
// exe_div: 32-step restoring divider, built
// only when EXE_DIV_EN is defined.
`ifdef EXE_DIV_EN
module exe_div
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sgn,
  input  logic        ack,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  div_state_e  state;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] b;
  logic        q_neg;
  logic        r_neg;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] q_nx;
  logic [31:0] r_nx;

  // one restoring step: shift in a dividend bit, try subtract
  always_comb begin
    rem_sh = {r, q[31]};
    diff   = rem_sh - {1'b0, b};
    if (diff[32]) begin
      r_nx = rem_sh[31:0];
      q_nx = {q[30:0], 1'b0};
    end else begin
      r_nx = diff[31:0];
      q_nx = {q[30:0], 1'b1};
    end
  end

  // IDLE/BUSY/DONE sequencing with sign fixup on the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      q         <= '0;
      r         <= '0;
      b         <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            q <= (sgn && dividend[31])
                 ? -dividend : dividend;
            b <= (sgn && divisor[31])
                 ? -divisor : divisor;
            r     <= '0;
            q_neg <= sgn
                     && (dividend[31] ^ divisor[31]);
            r_neg <= sgn && dividend[31];
            cnt   <= '0;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          q   <= q_nx;
          r   <= r_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            quotient  <= q_neg ? -q_nx : q_nx;
            remainder <= r_neg ? -r_nx : r_nx;
            done      <= 1'b1;
            state     <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (ack) begin
            done  <= 1'b0;
            state <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
`endif

// File: rtl/exe_stage.sv
// exe_stage: ALU/mul/div execute stage with SRAM request gen.
// Divider present only when EXE_DIV_EN is defined.
module exe_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        to_es_valid,
  input  logic [31:0] es_pc_in,
  input  logic [4:0]  alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] store_data,
  input  logic [3:0]  rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic        ms_allow_in,
  output logic        es_valid,
  output logic        es_allow_in,
  output logic        es_ready_go,
  output logic        to_ms_valid,
  output logic [31:0] es_pc,
  output logic [3:0]  rf_we_out,
  output logic [4:0]  rf_waddr_out,
  output logic [31:0] rf_wdata_out,
  output logic        es_ale,
  exe_stage_if.master dmem
);

  logic [31:0] sum;
  logic [4:0]  sh;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] mul_s;
  logic [31:0] mulhu;
  logic [31:0] div_res;
  logic [31:0] alu_res;
  logic [3:0]  st_we;
  logic [31:0] st_data;
  logic        mis;

  assign sum = alu_src1 + alu_src2;
  assign sh  = alu_src2[4:0];
  assign a64 = {{32{alu_src1[31]}}, alu_src1};
  assign b64 = {{32{alu_src2[31]}}, alu_src2};
  assign mul_s = a64 * b64;
  // unsigned high word from the signed product
  assign mulhu = mul_s[63:32]
               + (alu_src1[31] ? alu_src2 : 32'd0)
               + (alu_src2[31] ? alu_src1 : 32'd0);

`ifdef EXE_DIV_EN
  logic        is_div;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign is_div = is_div_op(alu_op);

  exe_div u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (es_valid && is_div),
    .sgn       (alu_op == OP_DIV || alu_op == OP_MOD),
    .ack       (es_valid && ms_allow_in),
    .dividend  (alu_src1),
    .divisor   (alu_src2),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  assign es_ready_go = !is_div || div_done;
  assign div_res = (alu_op == OP_DIV || alu_op == OP_DIVU)
                 ? div_q : div_r;
`else
  assign es_ready_go = 1'b1;
  assign div_res     = '0;
`endif

  // result select across ALU, multiply and divide
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:   alu_res = sum;
      OP_SUB:   alu_res = alu_src1 - alu_src2;
      OP_SLT:   alu_res = {31'd0,
                  $signed(alu_src1) < $signed(alu_src2)};
      OP_SLTU:  alu_res = {31'd0, alu_src1 < alu_src2};
      OP_AND:   alu_res = alu_src1 & alu_src2;
      OP_OR:    alu_res = alu_src1 | alu_src2;
      OP_XOR:   alu_res = alu_src1 ^ alu_src2;
      OP_NOR:   alu_res = ~(alu_src1 | alu_src2);
      OP_SLL:   alu_res = alu_src1 << sh;
      OP_SRL:   alu_res = alu_src1 >> sh;
      OP_SRA:   alu_res = $unsigned(
                  $signed(alu_src1) >>> sh);
      OP_LUI:   alu_res = alu_src2;
      OP_MUL:   alu_res = mul_s[31:0];
      OP_MULH:  alu_res = mul_s[63:32];
      OP_MULHU: alu_res = mulhu;
      OP_DIV, OP_DIVU,
      OP_MOD, OP_MODU:
                alu_res = div_res;
      default:  alu_res = '0;
    endcase
  end

  // stage occupancy register
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allow_in) begin
      es_valid <= to_es_valid;
    end
  end

  assign es_allow_in = !es_valid
                     || (es_ready_go && ms_allow_in);
  assign to_ms_valid = es_valid && es_ready_go;

  assign es_pc        = es_pc_in;
  assign rf_we_out    = rf_we;
  assign rf_waddr_out = rf_waddr;
  assign rf_wdata_out = alu_res;

  // misalignment: half on odd byte, word off 4-byte boundary
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      mem_size == SZ_HALF: mis = sum[0];
      mem_size == SZ_WORD: mis = sum[1:0] != 2'b00;
      default:             mis = 1'b0;
    endcase
  end

  assign es_ale = es_valid && mem_en && mis;

  // byte lanes and replicated data for stores
  always_comb begin
    st_we   = 4'b0000;
    st_data = store_data;
    unique case (1'b1)
      mem_size == SZ_BYTE: begin
        st_we   = 4'b0001 << sum[1:0];
        st_data = {4{store_data[7:0]}};
      end
      mem_size == SZ_HALF: begin
        st_we   = sum[1] ? 4'b1100 : 4'b0011;
        st_data = {2{store_data[15:0]}};
      end
      mem_size == SZ_WORD: begin
        st_we   = 4'b1111;
        st_data = store_data;
      end
      default: begin
        st_we   = 4'b0000;
        st_data = store_data;
      end
    endcase
  end

  assign dmem.data_sram_en = es_valid && mem_en
                           && ms_allow_in && !es_ale;
  assign dmem.data_sram_we = (dmem.data_sram_en && mem_wr)
                           ? st_we : 4'b0000;
  assign dmem.data_sram_addr  = sum;
  assign dmem.data_sram_wdata = st_data;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized self-checking bench for exe_stage
// against a spec-level reference model.
module tb_exe_stage;

  logic        clk;
  logic        reset;
  logic        to_es_valid;
  logic [31:0] es_pc_in;
  logic [4:0]  alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic        mem_en;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] store_data;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic        ms_allow_in;
  logic        es_valid;
  logic        es_allow_in;
  logic        es_ready_go;
  logic        to_ms_valid;
  logic [31:0] es_pc;
  logic [3:0]  rf_we_out;
  logic [4:0]  rf_waddr_out;
  logic [31:0] rf_wdata_out;
  logic        es_ale;

  exe_stage_if dmem ();

  int errors;
  int checks;

`ifdef EXE_DIV_EN
  localparam int DIV_LAT = 33;
`else
  localparam int DIV_LAT = 0;
`endif

  exe_stage dut (
    .clk          (clk),
    .reset        (reset),
    .to_es_valid  (to_es_valid),
    .es_pc_in     (es_pc_in),
    .alu_op       (alu_op),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .store_data   (store_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .ms_allow_in  (ms_allow_in),
    .es_valid     (es_valid),
    .es_allow_in  (es_allow_in),
    .es_ready_go  (es_ready_go),
    .to_ms_valid  (to_ms_valid),
    .es_pc        (es_pc),
    .rf_we_out    (rf_we_out),
    .rf_waddr_out (rf_waddr_out),
    .rf_wdata_out (rf_wdata_out),
    .es_ale       (es_ale),
    .dmem         (dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  function automatic logic [31:0] ref_div(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
`ifdef EXE_DIV_EN
    int sa, sb;
    logic sgn, want_q;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    sgn = (op == 5'd15) || (op == 5'd17);
    want_q = (op == 5'd15) || (op == 5'd16);
    if (b == 0) begin
      q = (sgn && sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000
                 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return want_q ? q : r;
`else
    return (op == 5'd0) ? a & b & 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] ref_alu(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int sa, sb;
    longint p;
    longint unsigned ua, ub, pu;
    sa = a;
    sb = b;
    p  = longint'(sa) * longint'(sb);
    ua = a;
    ub = b;
    pu = ua * ub;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd3:  return (a < b) ? 32'd1 : 32'd0;
      5'd4:  return a & b;
      5'd5:  return a | b;
      5'd6:  return a ^ b;
      5'd7:  return ~(a | b);
      5'd8:  return a << b[4:0];
      5'd9:  return a >> b[4:0];
      5'd10: return sa >>> b[4:0];
      5'd11: return b;
      5'd12: return p[31:0];
      5'd13: return p[63:32];
      5'd14: return pu[63:32];
      5'd15, 5'd16, 5'd17, 5'd18:
             return ref_div(op, a, b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return $urandom_range(0, 40);
      1: return -$urandom_range(1, 40);
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction; returns in its entry cycle (E0)
  task automatic drive(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic men,
    input logic mwr,
    input logic [1:0] msz,
    input logic [31:0] sd
  );
    @(negedge clk);
    alu_op      = op;
    alu_src1    = a;
    alu_src2    = b;
    mem_en      = men;
    mem_wr      = mwr;
    mem_size    = msz;
    store_data  = sd;
    es_pc_in    = $urandom;
    rf_we       = 4'($urandom);
    rf_waddr    = 5'($urandom);
    to_es_valid = 1'b1;
    @(posedge clk);
    #1;
    to_es_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    to_es_valid = 1'b0;
    ms_allow_in = 1'b1;
    alu_op = 0; alu_src1 = 0; alu_src2 = 0;
    mem_en = 0; mem_wr = 0; mem_size = 0;
    store_data = 0; es_pc_in = 0;
    rf_we = 0; rf_waddr = 0;
    step();
    step();
    checks++;
    if (es_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset es_valid got=%b exp=0", es_valid);
    end
    reset = 1'b0;
    step();
    checks++;
    if (es_valid !== 1'b0 || to_ms_valid !== 1'b0
        || es_allow_in !== 1'b1) begin
      errors++;
      $display("FAIL reset hs valid=%b tms=%b allow=%b exp 0,0,1",
               es_valid, to_ms_valid, es_allow_in);
    end
    checks++;
    if (dmem.data_sram_en !== 1'b0
        || dmem.data_sram_we !== 4'b0) begin
      errors++;
      $display("FAIL reset sram en=%b we=%b exp 0,0",
               dmem.data_sram_en, dmem.data_sram_we);
    end
  endtask

  task automatic test_add_spec();
    ms_allow_in = 1'b1;
    drive(5'd0, 32'd5, 32'hFFFF_FFFF, 0, 0, 0, 0);
    checks++;
    if (rf_wdata_out !== 32'd4 || to_ms_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_spec res=%h tms=%b exp 4,1",
               rf_wdata_out, to_ms_valid);
    end
    step();
    checks++;
    if (es_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain es_valid=%b exp 0", es_valid);
    end
  endtask

  task automatic test_alu_random();
    logic [4:0] op;
    logic [31:0] a, b, exp;
    ms_allow_in = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op >= 5'd15 && op <= 5'd18) op = op - 5'd4;
      a = rnd_val();
      b = rnd_val();
      exp = ref_alu(op, a, b);
      drive(op, a, b, 0, 0, 0, 0);
      checks++;
      if (rf_wdata_out !== exp) begin
        errors++;
        $display("FAIL alu op=%0d a=%h b=%h got=%h exp=%h",
                 op, a, b, rf_wdata_out, exp);
      end
      checks++;
      if (es_ready_go !== 1'b1 || to_ms_valid !== 1'b1
          || dmem.data_sram_en !== 1'b0) begin
        errors++;
        $display("FAIL alu_hs op=%0d rg=%b tms=%b en=%b exp 1,1,0",
                 op, es_ready_go, to_ms_valid, dmem.data_sram_en);
      end
      checks++;
      if (es_pc !== es_pc_in || rf_we_out !== rf_we
          || rf_waddr_out !== rf_waddr) begin
        errors++;
        $display("FAIL pass pc=%h we=%h wa=%0d", es_pc,
                 rf_we_out, rf_waddr_out);
      end
      step();
    end
  endtask

  task automatic test_mem_random();
    logic [31:0] a, b, sd, addr, wd;
    logic [1:0] sz;
    logic wr, ale, en;
    logic [3:0] we;
    ms_allow_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 2));
      wr = 1'($urandom);
      a  = $urandom;
      b  = $urandom_range(0, 15);
      sd = $urandom;
      addr = a + b;
      ale = (sz == 2'd1 && addr[0])
         || (sz == 2'd2 && addr[1:0] != 2'd0);
      en = !ale;
      we = 4'b0000;
      if (wr && en) begin
        if (sz == 2'd0) we[addr[1:0]] = 1'b1;
        else if (sz == 2'd1) we = addr[1] ? 4'hC : 4'h3;
        else we = 4'hF;
      end
      wd = (sz == 2'd0) ? {4{sd[7:0]}}
         : (sz == 2'd1) ? {2{sd[15:0]}} : sd;
      drive(5'd0, a, b, 1, wr, sz, sd);
      checks++;
      if (es_ale !== ale || dmem.data_sram_en !== en
          || dmem.data_sram_we !== we) begin
        errors++;
        $display("FAIL mem sz=%0d wr=%b ad=%h ale=%b en=%b we=%b exp %b,%b,%b",
                 sz, wr, addr, es_ale, dmem.data_sram_en,
                 dmem.data_sram_we, ale, en, we);
      end
      checks++;
      if (dmem.data_sram_addr !== addr
          || dmem.data_sram_wdata !== wd
          || rf_wdata_out !== addr) begin
        errors++;
        $display("FAIL mem_data ad=%h wd=%h res=%h exp %h,%h",
                 dmem.data_sram_addr, dmem.data_sram_wdata,
                 rf_wdata_out, addr, wd);
      end
      step();
    end
  endtask

  task automatic test_mem_directed();
    ms_allow_in = 1'b1;
    drive(5'd0, 32'h1000, 32'd3, 1, 1, 2'd0, 32'h1234_5678);
    checks++;
    if (dmem.data_sram_we !== 4'b1000
        || dmem.data_sram_wdata !== 32'h7878_7878
        || dmem.data_sram_en !== 1'b1) begin
      errors++;
      $display("FAIL sb_1003 we=%b wd=%h en=%b exp 1000,78787878,1",
               dmem.data_sram_we, dmem.data_sram_wdata,
               dmem.data_sram_en);
    end
    step();
    drive(5'd0, 32'h1000, 32'd2, 1, 0, 2'd2, 32'd0);
    checks++;
    if (es_ale !== 1'b1 || dmem.data_sram_en !== 1'b0) begin
      errors++;
      $display("FAIL lw_1002 ale=%b en=%b exp 1,0",
               es_ale, dmem.data_sram_en);
    end
    step();
    ms_allow_in = 1'b0;
    drive(5'd0, 32'h2000, 32'd4, 1, 1, 2'd2, 32'hCAFE_F00D);
    checks++;
    if (dmem.data_sram_en !== 1'b0 || dmem.data_sram_we !== 4'b0
        || es_allow_in !== 1'b0) begin
      errors++;
      $display("FAIL sw_stall en=%b we=%b allow=%b exp 0,0,0",
               dmem.data_sram_en, dmem.data_sram_we, es_allow_in);
    end
    ms_allow_in = 1'b1;
    #1;
    checks++;
    if (dmem.data_sram_en !== 1'b1 || dmem.data_sram_we !== 4'hF
        || dmem.data_sram_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL sw_go en=%b we=%b wd=%h exp 1,1111,cafef00d",
               dmem.data_sram_en, dmem.data_sram_we,
               dmem.data_sram_wdata);
    end
    step();
  endtask

  task automatic run_div(
    input logic [4:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int n;
    logic [31:0] exp;
    exp = ref_alu(op, a, b);
    ms_allow_in = 1'b1;
    drive(op, a, b, 0, 0, 0, 0);
    n = 0;
    while (es_ready_go !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n != DIV_LAT) begin
      errors++;
      $display("FAIL div_lat op=%0d got=%0d exp=%0d",
               op, n, DIV_LAT);
    end
    checks++;
    if (rf_wdata_out !== exp || to_ms_valid !== 1'b1) begin
      errors++;
      $display("FAIL div op=%0d a=%h b=%h got=%h exp=%h tms=%b",
               op, a, b, rf_wdata_out, exp, to_ms_valid);
    end
    step();
  endtask

  task automatic test_div();
    run_div(5'd15, -32'sd7, 32'd2);
    run_div(5'd17, -32'sd7, 32'd2);
    run_div(5'd16, 32'd9, 32'd0);
    run_div(5'd18, 32'd9, 32'd0);
    run_div(5'd15, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(5'd17, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div(5'd15, -32'sd9, 32'd0);
    run_div(5'd17, 32'd100, -32'sd7);
    for (int i = 0; i < 6; i++) begin
      run_div(5'($urandom_range(15, 18)), rnd_val(),
              rnd_val());
    end
  endtask

  task automatic test_div_stall();
    int n;
    logic [31:0] exp;
    exp = ref_alu(5'd15, 32'd100, 32'd7);
    ms_allow_in = 1'b0;
    drive(5'd15, 32'd100, 32'd7, 0, 0, 0, 0);
    n = 0;
    while (es_ready_go !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n != DIV_LAT) begin
      errors++;
      $display("FAIL stall_lat got=%0d exp=%0d", n, DIV_LAT);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rf_wdata_out !== exp || es_allow_in !== 1'b0
          || to_ms_valid !== 1'b1 || es_ready_go !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold i=%0d res=%h allow=%b tms=%b rg=%b exp %h,0,1,1",
                 i, rf_wdata_out, es_allow_in, to_ms_valid,
                 es_ready_go, exp);
      end
      step();
    end
    ms_allow_in = 1'b1;
    #1;
    checks++;
    if (es_allow_in !== 1'b1) begin
      errors++;
      $display("FAIL stall_release allow=%b exp 1", es_allow_in);
    end
    step();
    checks++;
    if (es_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain es_valid=%b exp 0", es_valid);
    end
    run_div(5'd16, 32'd77, 32'd5);
  endtask

  task automatic test_div_reset();
    ms_allow_in = 1'b0;
    drive(5'd15, -32'sd100, 32'd3, 0, 0, 0, 0);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (es_valid !== 1'b0 || es_allow_in !== 1'b1
        || to_ms_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid valid=%b allow=%b tms=%b exp 0,1,0",
               es_valid, es_allow_in, to_ms_valid);
    end
    ms_allow_in = 1'b1;
    drive(5'd0, 32'd20, 32'd22, 0, 0, 0, 0);
    checks++;
    if (rf_wdata_out !== 32'd42 || to_ms_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_add res=%h tms=%b exp 2a,1",
               rf_wdata_out, to_ms_valid);
    end
    step();
    run_div(5'd15, -32'sd100, 32'd3);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add_spec();
    test_alu_random();
    test_mem_random();
    test_mem_directed();
    test_div();
    test_div_stall();
    test_div_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
